vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
- Synthesizable, parametrised monitor that sits on any vga_if stage, e.g. after draw.
- Measures hsync/vsync timing against a configured video mode and counts active pixels per frame.
- Computes a per-frame CRC of active-pixel RGB, so benches and on-chip logic can compare frames without a TIFF dump.
- Reports results once per frame, with sticky error flags.

Parameters:
- H_TOTAL, 1328, expected clocks per line
- H_ACTIVE, 1024, expected active pixels per line
- H_SYNC, 136, expected hsync width in clocks
- V_TOTAL, 806, expected lines per frame
- V_ACTIVE, 768, expected active lines per frame
- V_SYNC, 6, expected vsync width in lines
- SYNC_POL, 1'b1, sync active level (1 = active-high)
- RGB_W, 12, pixel width ({r,g,b})

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- hblnk  in  1  horizontal blank
- vblnk  in  1  vertical blank
- rgb  in  RGB_W  pixel data
- clr_err  in  1  clears sticky err
- locked  out  1  high after the first vsync active edge since reset
- frame_done  out  1  one-cycle pulse per completed frame
- frame_ok  out  1  valid with frame_done; frame had no errors
- frame_count  out  16  completed frames, wraps at 0xFFFF->0
- h_total_meas  out  16  clocks of last complete line of last frame
- v_total_meas  out  16  lines of last frame
- pix_count  out  24  active pixels of last frame
- frame_crc  out  16  CRC of last frame's active pixels
- err  out  4  sticky: [0] h_total, [1] h_sync width, [2] v_total/v_sync, [3] pix_count

Behaviour:
- Reset: all outputs 0; state SEEK; internal CRC = 0xFFFF; counters 0; previous-sync registers = inactive level.
- Active edge: signal equals SYNC_POL at cycle N and did not at N-1. Active pixel: hblnk==0 && vblnk==0.
- FSM SEEK -> ARMED on the first vsync active edge (locked<=1). ARMED -> RUN on the next vsync active edge. RUN stays in RUN. rst from any state returns to SEEK.
- The first partial frame after reset is never reported.
- Frame boundary: vsync active edge at cycle N.
  - The cycle-N pixel, and any hsync edge at cycle N, belong to the new frame.
  - In RUN at boundary N: latch v_total_meas, pix_count, frame_crc, h_total_meas.
  - frame_done=1 and frame_ok=(no error detected in the closing frame) at N+1.
  - frame_count increments at N+1.
  - Counters and CRC restart at N.
- Line measurement: clocks between consecutive hsync active edges within the frame. Each complete line ≠ H_TOTAL sets err[0]. The hsync active width (level cycles) ≠ H_SYNC sets err[1].
- v_total = count of hsync active edges in [boundary, next boundary). Mismatch with V_TOTAL sets err[2] at the boundary. Hsync edges counted while vsync is active ≠ V_SYNC also sets err[2].
- pix_count ≠ H_ACTIVE*V_ACTIVE sets err[3] at the boundary.
- Errors are checked only in ARMED/RUN; errors in ARMED frames set err but produce no frame_done.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR. RGB_W bits per active pixel, MSB first, one pixel per clock.
- Counters saturate at all-ones (line counter 16b, pix counter 24b), so a missing sync cannot wrap.
- err bits are sticky until clr_err. If clr_err coincides with a new error, the new error wins (bit stays set).
- frame_ok reflects only the closing frame, independent of sticky history.

Test Plan:
- Nominal: drive from vga_timing (1024x768, 75 MHz) for 3 vsync edges -> locked=1; one frame_done; frame_count=1; h_total_meas=1328; v_total_meas=806; pix_count=786432; err=0; frame_ok=1.
- Small mode (H_TOTAL=20, H_ACTIVE=12, H_SYNC=2, V_TOTAL=10, V_ACTIVE=6, V_SYNC=1), bench-generated syncs, constant rgb=12'hABC -> pix_count=72; frame_crc equals the bench reference model; two consecutive frames give identical CRC.
- Same small mode, one line stretched to 21 clocks in frame 3 -> err[0]=1 and frame_ok=0 for frame 3 only. err[0] stays set through frame 4 (frame_ok=1) until a clr_err pulse -> err=0.
- Single pixel changed in frame 4 -> frame_crc differs from frame 3; err=0; frame_ok=1.
- vsync width 2 lines -> err[2]=1. Pixel enable dropped for one cycle -> pix_count=71; err[3]=1.
- rst asserted mid-frame in RUN -> all outputs 0 next cycle. No frame_done until the second vsync edge after reset. frame_count restarts at 1.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Passive monitor for a VGA-style stream (hsync/vsync/hblnk/vblnk/rgb).
// It checks the sync timing against one fixed video mode, counts the active
// pixels and computes a CRC-16-CCITT over the active RGB values of each frame.
// Results for a frame are latched at the next vsync active edge. Error flags
// stay set until clr_err.
module vga_frame_monitor #(
    parameter int   H_TOTAL  = 1328,
    parameter int   H_ACTIVE = 1024,
    parameter int   H_SYNC   = 136,
    parameter int   V_TOTAL  = 806,
    parameter int   V_ACTIVE = 768,
    parameter int   V_SYNC   = 6,
    parameter logic SYNC_POL = 1'b1,
    parameter int   RGB_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             hblnk,
    input  logic             vblnk,
    input  logic [RGB_W-1:0] rgb,
    input  logic             clr_err,
    output logic             locked,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [15:0]      frame_count,
    output logic [15:0]      h_total_meas,
    output logic [15:0]      v_total_meas,
    output logic [23:0]      pix_count,
    output logic [15:0]      frame_crc,
    output logic [3:0]       err
);

    localparam logic [15:0] H_TOTAL_C = 16'(H_TOTAL);
    localparam logic [15:0] H_SYNC_C  = 16'(H_SYNC);
    localparam logic [15:0] V_TOTAL_C = 16'(V_TOTAL);
    localparam logic [15:0] V_SYNC_C  = 16'(V_SYNC);
    localparam logic [23:0] PIX_EXP_C = 24'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {SEEK, ARMED, RUN} state_t;

    // Counters hold at all-ones so a missing sync cannot wrap them back into range.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    // CRC-16-CCITT (0x1021), one pixel per call, MSB of the pixel first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [RGB_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        line_seen_q, line_seen_d;
    logic [15:0] last_line_q, last_line_d;
    logic [15:0] hsw_cnt_q, hsw_cnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [15:0] vs_hcnt_q, vs_hcnt_d;
    logic [23:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [3:0]  frame_err_q, frame_err_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] h_total_meas_q, h_total_meas_d;
    logic [15:0] v_total_meas_q, v_total_meas_d;
    logic [23:0] pix_count_q, pix_count_d;
    logic [15:0] frame_crc_q, frame_crc_d;
    logic [3:0]  err_q, err_d;

    logic hs_act, vs_act, hs_edge, hs_fall, vs_edge, pix_en, chk_en;
    logic line_err, hsw_err;
    logic [3:0] cyc_err, bnd_err, closing_err, new_err;

    // Decode sync levels and edges; the previous-level registers store raw pins.
    always_comb begin
        hs_act    = (hsync == SYNC_POL);
        vs_act    = (vsync == SYNC_POL);
        hs_edge   = hs_act && (hs_prev_q != SYNC_POL);
        hs_fall   = !hs_act && (hs_prev_q == SYNC_POL);
        vs_edge   = vs_act && (vs_prev_q != SYNC_POL);
        pix_en    = !hblnk && !vblnk;
        chk_en    = (state_q != SEEK);
        hs_prev_d = hsync;
        vs_prev_d = vsync;
    end

    // Lock sequence: first vsync edge locks, second starts reporting frames.
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        case (state_q)
            SEEK: begin
                if (vs_edge) begin
                    state_d  = ARMED;
                    locked_d = 1'b1;
                end
            end
            ARMED:   if (vs_edge) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SEEK;
        endcase
    end

    // Line length between hsync edges of the same frame, and hsync pulse width.
    always_comb begin
        line_cnt_d  = sat_inc16(line_cnt_q);
        line_seen_d = line_seen_q;
        last_line_d = last_line_q;
        hsw_cnt_d   = hsw_cnt_q;
        line_err    = 1'b0;
        // An edge coinciding with the frame boundary opens the new frame, so the
        // line spanning the boundary is not measured.
        if (vs_edge) begin
            line_seen_d = 1'b0;
            last_line_d = 16'd0;
        end
        if (hs_edge) begin
            if (line_seen_q && !vs_edge) begin
                last_line_d = line_cnt_q;
                line_err    = (line_cnt_q != H_TOTAL_C);
            end
            line_cnt_d  = 16'd1;
            line_seen_d = 1'b1;
        end
        if (hs_act) begin
            hsw_cnt_d = hs_edge ? 16'd1 : sat_inc16(hsw_cnt_q);
        end
        hsw_err = hs_fall && (hsw_cnt_q != H_SYNC_C);
    end

    // Per-frame accumulators; at the boundary they restart with the cycle-N contribution.
    always_comb begin
        vcnt_d    = vcnt_q;
        vs_hcnt_d = vs_hcnt_q;
        pix_cnt_d = pix_cnt_q;
        crc_d     = crc_q;
        if (vs_edge) begin
            vcnt_d    = {15'd0, hs_edge};
            vs_hcnt_d = {15'd0, hs_edge};
            pix_cnt_d = {23'd0, pix_en};
            crc_d     = pix_en ? crc_step(16'hFFFF, rgb) : 16'hFFFF;
        end else begin
            if (hs_edge) begin
                vcnt_d = sat_inc16(vcnt_q);
            end
            if (hs_edge && vs_act) begin
                vs_hcnt_d = sat_inc16(vs_hcnt_q);
            end
            if (pix_en) begin
                pix_cnt_d = sat_inc24(pix_cnt_q);
                crc_d     = crc_step(crc_q, rgb);
            end
        end
    end

    // Error collection, sticky flags and the once-per-frame report.
    always_comb begin
        cyc_err     = {2'b00, hsw_err, line_err};
        bnd_err     = {(pix_cnt_q != PIX_EXP_C),
                       (vcnt_q != V_TOTAL_C) || (vs_hcnt_q != V_SYNC_C),
                       2'b00};
        closing_err = frame_err_q | bnd_err;
        new_err     = 4'b0000;
        if (chk_en) begin
            new_err = cyc_err | (vs_edge ? bnd_err : 4'b0000);
        end
        // A new error in the same cycle as clr_err keeps its bit set.
        err_d = (clr_err ? 4'b0000 : err_q) | new_err;

        // Errors seen in the boundary cycle belong to the frame that starts there.
        frame_err_d = frame_err_q | (chk_en ? cyc_err : 4'b0000);
        if (vs_edge) begin
            frame_err_d = chk_en ? cyc_err : 4'b0000;
        end

        frame_done_d   = 1'b0;
        frame_ok_d     = 1'b0;
        frame_count_d  = frame_count_q;
        h_total_meas_d = h_total_meas_q;
        v_total_meas_d = v_total_meas_q;
        pix_count_d    = pix_count_q;
        frame_crc_d    = frame_crc_q;
        if (vs_edge && (state_q == RUN)) begin
            frame_done_d   = 1'b1;
            frame_ok_d     = (closing_err == 4'b0000);
            frame_count_d  = frame_count_q + 16'd1;
            h_total_meas_d = last_line_q;
            v_total_meas_d = vcnt_q;
            pix_count_d    = pix_cnt_q;
            frame_crc_d    = crc_q;
        end
    end

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SEEK;
            hs_prev_q      <= ~SYNC_POL;
            vs_prev_q      <= ~SYNC_POL;
            line_cnt_q     <= 16'd0;
            line_seen_q    <= 1'b0;
            last_line_q    <= 16'd0;
            hsw_cnt_q      <= 16'd0;
            vcnt_q         <= 16'd0;
            vs_hcnt_q      <= 16'd0;
            pix_cnt_q      <= 24'd0;
            crc_q          <= 16'hFFFF;
            frame_err_q    <= 4'b0000;
            locked_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_ok_q     <= 1'b0;
            frame_count_q  <= 16'd0;
            h_total_meas_q <= 16'd0;
            v_total_meas_q <= 16'd0;
            pix_count_q    <= 24'd0;
            frame_crc_q    <= 16'd0;
            err_q          <= 4'b0000;
        end else begin
            state_q        <= state_d;
            hs_prev_q      <= hs_prev_d;
            vs_prev_q      <= vs_prev_d;
            line_cnt_q     <= line_cnt_d;
            line_seen_q    <= line_seen_d;
            last_line_q    <= last_line_d;
            hsw_cnt_q      <= hsw_cnt_d;
            vcnt_q         <= vcnt_d;
            vs_hcnt_q      <= vs_hcnt_d;
            pix_cnt_q      <= pix_cnt_d;
            crc_q          <= crc_d;
            frame_err_q    <= frame_err_d;
            locked_q       <= locked_d;
            frame_done_q   <= frame_done_d;
            frame_ok_q     <= frame_ok_d;
            frame_count_q  <= frame_count_d;
            h_total_meas_q <= h_total_meas_d;
            v_total_meas_q <= v_total_meas_d;
            pix_count_q    <= pix_count_d;
            frame_crc_q    <= frame_crc_d;
            err_q          <= err_d;
        end
    end

    assign locked       = locked_q;
    assign frame_done   = frame_done_q;
    assign frame_ok     = frame_ok_q;
    assign frame_count  = frame_count_q;
    assign h_total_meas = h_total_meas_q;
    assign v_total_meas = v_total_meas_q;
    assign pix_count    = pix_count_q;
    assign frame_crc    = frame_crc_q;
    assign err          = err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Testbench for vga_frame_monitor in a small 20x10 video mode.
// The bench generates the sync/blank/rgb stream itself, models each frame's
// expected report and queues it; reports are popped when frame_done fires.
module tb_vga_frame_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        hblnk = 1'b1;
    logic        vblnk = 1'b1;
    logic [11:0] rgb = 12'h000;
    logic        clr_err = 1'b0;
    logic        locked, frame_done, frame_ok;
    logic [15:0] frame_count, h_total_meas, v_total_meas, frame_crc;
    logic [23:0] pix_count;
    logic [3:0]  err;

    vga_frame_monitor #(
        .H_TOTAL(20), .H_ACTIVE(12), .H_SYNC(2),
        .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC(1),
        .SYNC_POL(1'b1), .RGB_W(12)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .hblnk(hblnk), .vblnk(vblnk), .rgb(rgb), .clr_err(clr_err),
        .locked(locked), .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_count(frame_count), .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas), .pix_count(pix_count),
        .frame_crc(frame_crc), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ok;
        logic [15:0] fc;
        logic [15:0] ht;
        logic [15:0] vt;
        logic [23:0] pix;
        logic [15:0] crc;
        logic [3:0]  err;
    } rec_t;

    rec_t        sb_q[$];
    logic [15:0] rep_crc[$];
    int          checks = 0;
    int          errors = 0;

    // Frame model state
    int          fidx = 0;
    int          m_t, m_edges, m_vs_edges, m_last_edge, m_last_line, m_pix;
    logic [15:0] m_crc;
    logic        m_line_err;
    logic [3:0]  exp_err = 4'b0000;
    logic [15:0] exp_fc = 16'd0;

    // Reference CRC-16-CCITT: align the pixel with the top of the register, then shift.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c ^ {d, 4'b0000};
        for (int i = 0; i < 12; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare any report the DUT produced against the queue.
    task automatic tick();
        rec_t r;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_frame_done", 32'(sb_q.size()), 32'd1);
            end else begin
                r = sb_q.pop_front();
                chk("frame_ok",     32'(frame_ok),     32'(r.ok));
                chk("frame_count",  32'(frame_count),  32'(r.fc));
                chk("h_total_meas", 32'(h_total_meas), 32'(r.ht));
                chk("v_total_meas", 32'(v_total_meas), 32'(r.vt));
                chk("pix_count",    32'(pix_count),    32'(r.pix));
                chk("frame_crc",    32'(frame_crc),    32'(r.crc));
                chk("err_at_report", 32'(err),         32'(r.err));
                rep_crc.push_back(frame_crc);
            end
        end
    endtask

    task automatic drive_line(input int vc, input int len, input bit vs_on,
                              input bit drop, input bit chg, input int clr_cyc);
        logic hb, vb, en;
        for (int hc = 0; hc < len; hc++) begin
            hb      = (hc >= 12) || (drop && vc == 0 && hc == 3);
            vb      = (vc >= 6);
            en      = !hb && !vb;
            hsync   = (hc == 14) || (hc == 15);
            vsync   = vs_on;
            hblnk   = hb;
            vblnk   = vb;
            if (en) rgb = (chg && vc == 1 && hc == 5) ? 12'h123 : 12'hABC;
            else    rgb = 12'(hc * 7 + vc * 3);
            clr_err = (m_t == clr_cyc);
            if (m_t == clr_cyc && m_t != 0) exp_err = 4'b0000;
            if (hc == 14) begin
                m_edges++;
                if (vs_on) m_vs_edges++;
                if (m_last_edge >= 0) begin
                    m_last_line = m_t - m_last_edge;
                    if (m_last_line != 20) m_line_err = 1'b1;
                end
                m_last_edge = m_t;
            end
            if (en) begin
                m_pix++;
                m_crc = ref_crc(m_crc, rgb);
            end
            tick();
            m_t++;
        end
        clr_err = 1'b0;
    endtask

    // One monitor frame, starting with the vsync active edge at line 7.
    task automatic drive_frame(input int stretch, input int vsl, input bit drop,
                               input bit chg, input int clr_cyc, input int nlines);
        logic [3:0] bnd;
        rec_t r;
        int vc;
        bnd = {(m_pix != 72), (m_edges != 10) || (m_vs_edges != 1), 2'b00};
        if (clr_cyc == 0) exp_err = 4'b0000;
        if (fidx >= 1) exp_err = exp_err | bnd;
        if (fidx >= 2) begin
            exp_fc++;
            r.ok  = ((bnd | {3'b000, m_line_err}) == 4'b0000);
            r.fc  = exp_fc;
            r.ht  = 16'(m_last_line);
            r.vt  = 16'(m_edges);
            r.pix = 24'(m_pix);
            r.crc = m_crc;
            r.err = exp_err;
            sb_q.push_back(r);
        end
        fidx++;
        m_t = 0; m_edges = 0; m_vs_edges = 0; m_last_edge = -1;
        m_last_line = 0; m_pix = 0; m_crc = 16'hFFFF; m_line_err = 1'b0;
        for (int i = 0; i < nlines; i++) begin
            vc = (7 + i) % 10;
            drive_line(vc, (vc == stretch) ? 21 : 20,
                       (vc == 7) || (vsl == 2 && vc == 8), drop, chg, clr_cyc);
        end
        exp_err = exp_err | {3'b000, m_line_err};
    endtask

    task automatic lead_in();
        m_t = 0; m_edges = 0; m_vs_edges = 0; m_last_edge = -1;
        m_last_line = 0; m_pix = 0; m_crc = 16'hFFFF; m_line_err = 1'b0;
        for (int v = 0; v < 7; v++) drive_line(v, 20, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"},      32'(locked),       32'd0);
        chk({tag, "_frame_done"},  32'(frame_done),   32'd0);
        chk({tag, "_frame_ok"},    32'(frame_ok),     32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count),  32'd0);
        chk({tag, "_h_total"},     32'(h_total_meas), 32'd0);
        chk({tag, "_v_total"},     32'(v_total_meas), 32'd0);
        chk({tag, "_pix_count"},   32'(pix_count),    32'd0);
        chk({tag, "_frame_crc"},   32'(frame_crc),    32'd0);
        chk({tag, "_err"},         32'(err),          32'd0);
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Partial frame, then lock and start reporting
        lead_in();
        chk("locked_before_vsync", 32'(locked), 32'd0);
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);            // F1: armed, never reported
        chk("locked_after_vsync", 32'(locked), 32'd1);
        chk("no_report_armed", 32'(frame_count), 32'd0);
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);            // F2: nominal
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);            // F3: nominal, same CRC
        drive_frame( 2, 1, 1'b0, 1'b0, -1, 10);            // F4: one 21-clock line
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);            // F5: clean, err0 still sticky
        drive_frame(-1, 1, 1'b0, 1'b1,  2, 10);            // F6: clr_err, one pixel changed
        chk("err_cleared", 32'(err), 32'd0);
        chk("crc_repeat", 32'(rep_crc[1]), 32'(rep_crc[0]));
        drive_frame(-1, 2, 1'b0, 1'b0, -1, 10);            // F7: vsync two lines wide
        chk("crc_changed", 32'(rep_crc[4] !== rep_crc[3]), 32'd1);
        drive_frame(-1, 1, 1'b1, 1'b0,  0, 10);            // F8: clr at boundary, dropped pixel
        chk("clr_vs_new_err", 32'(err), 32'h4);
        drive_frame(-1, 1, 1'b0, 1'b0,  2, 3);             // F9: reset arrives mid-frame
        chk("err_cleared_again", 32'(err), 32'd0);

        // Mid-frame reset while running
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        fidx = 0; exp_err = 4'b0000; exp_fc = 16'd0;

        lead_in();
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);
        chk("no_done_after_rst", 32'(frame_count), 32'd0);
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);
        drive_frame(-1, 1, 1'b0, 1'b0, -1, 10);            // reports F2' with frame_count 1
        chk("count_restart", 32'(frame_count), 32'd1);
        tick(); tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("report_total", 32'(rep_crc.size()), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
